// File: rtl/snake_pkg.sv
// Shared types for the snake direction controller.
//   dir_t    : direction encoding UP=0, DOWN=1, LEFT=2, RIGHT=3
//   state_t  : controller FSM states
//   opposite : returns the 180-degree reversal of a direction
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Bundle between the player/game side and the snake head register.
//   key_up/down/left/right : raw keys, active-high, asynchronous to clk
//   pause, dead            : synchronous control from game logic
//   up/down/left/right     : one-cycle step pulses to the head register
//   dir                    : committed direction
//   step                   : one-cycle pulse coincident with any direction pulse
// master = direction controller, slave = environment / head register side.
interface snake_dir_ctrl_if;

  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       pause;
  logic       dead;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [1:0] dir;
  logic       step;

  modport master (
    input  key_up, key_down, key_left, key_right, pause, dead,
    output up, down, left, right, dir, step
  );

  modport slave (
    output key_up, key_down, key_left, key_right, pause, dead,
    input  up, down, left, right, dir, step
  );

endinterface

// File: rtl/key_edge.sv
// Raw key conditioning: 2-flop synchronizer followed by rising-edge detect.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   key   : raw asynchronous key level
//   pulse : one-cycle pulse, valid two edges after the key rises; it is
//           consumed by the controller on the third edge
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= key;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign pulse = sync2 & ~sync_d;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: turns raw direction keys into step pulses for
// the head position register at a fixed game-step rate, enforcing the
// no-reversal rule and at most one committed turn per step.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   bus       : snake_dir_ctrl_if master (keys, pause, dead in; pulses, dir, step out)
//   dbg_state : current FSM state, for observation only
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         STEP_CYCLES = 8333333,
  parameter int         CNT_W       = 24,
  parameter logic [1:0] START_DIR   = 2'd3
) (
  input  logic                    clk,
  input  logic                    reset,
  snake_dir_ctrl_if.master        bus,
  output state_t                  dbg_state
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  dir_t             dir_q;
  dir_t             pending_q;
  logic [3:0]       pulse_q, pulse_d;   // one-hot, indexed by dir_t
  logic             step_q, step_d;

  logic e_up, e_down, e_left, e_right;
  logic req_valid;
  dir_t req_dir;
  logic accept;
  logic fire;

  key_edge u_key_up    (.clk(clk), .reset(reset), .key(bus.key_up),    .pulse(e_up));
  key_edge u_key_down  (.clk(clk), .reset(reset), .key(bus.key_down),  .pulse(e_down));
  key_edge u_key_left  (.clk(clk), .reset(reset), .key(bus.key_left),  .pulse(e_left));
  key_edge u_key_right (.clk(clk), .reset(reset), .key(bus.key_right), .pulse(e_right));

  // Fixed priority UP > DOWN > LEFT > RIGHT; only one request per cycle.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    if (e_up)         req_dir = DIR_UP;
    else if (e_down)  req_dir = DIR_DOWN;
    else if (e_left)  req_dir = DIR_LEFT;
    else if (e_right) req_dir = DIR_RIGHT;
    else              req_valid = 1'b0;
  end

  // Checked against the committed direction, so a turn queued earlier in
  // the same step cannot be used as a stepping stone to a reversal.
  assign accept = req_valid && (req_dir != opposite(dir_q)) &&
                  !bus.dead && (state_q != S_DEAD);

  // Terminal count while running and not paused; dead overrides.
  assign fire = (state_q == S_RUN) && !bus.pause && !bus.dead && (cnt_q == TERM);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; dead wins over every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dead)    state_d = S_DEAD;
        else if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.dead)    state_d = S_DEAD;
      end
      S_DEAD:            state_d = S_DEAD;
      default:           state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered pulses. The pulse
  // follows pending, which is the dir being committed on the same edge.
  always_comb begin
    pulse_d          = 4'b0000;
    step_d           = fire;
    pulse_d[pending_q] = fire;
  end

  // Counter, committed/pending direction and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      dir_q     <= dir_t'(START_DIR);
      pending_q <= dir_t'(START_DIR);
      pulse_q   <= 4'b0000;
      step_q    <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      step_q  <= step_d;

      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (state_q == S_RUN && !bus.dead && !bus.pause) begin
        cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
      end

      if (fire)   dir_q     <= pending_q;
      if (accept) pending_q <= req_dir;
    end
  end

  assign bus.up    = pulse_q[DIR_UP];
  assign bus.down  = pulse_q[DIR_DOWN];
  assign bus.left  = pulse_q[DIR_LEFT];
  assign bus.right = pulse_q[DIR_RIGHT];
  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with STEP_CYCLES=4, START_DIR=RIGHT.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     checks;
  int     errors;
  int     n;
  int     cnt;

  snake_dir_ctrl_if bus_if ();

  snake_dir_ctrl #(
    .STEP_CYCLES(4),
    .CNT_W(24),
    .START_DIR(2'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic press_up();    bus_if.key_up = 1'b1;    tick(); bus_if.key_up = 1'b0;    endtask
  task automatic press_down();  bus_if.key_down = 1'b1;  tick(); bus_if.key_down = 1'b0;  endtask
  task automatic press_left();  bus_if.key_left = 1'b1;  tick(); bus_if.key_left = 1'b0;  endtask
  task automatic press_right(); bus_if.key_right = 1'b1; tick(); bus_if.key_right = 1'b0; endtask

  // Waits for a step pulse, checking every cycle that exactly the number of
  // direction pulses equals step. Returns the number of edges waited.
  task automatic wait_pulse(input int max, output int waited);
    logic got;
    int   sum;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < max) begin
      tick();
      waited++;
      sum = int'(bus_if.up) + int'(bus_if.down) + int'(bus_if.left) + int'(bus_if.right);
      chk("pulses_vs_step", 32'(sum), 32'(bus_if.step));
      if (bus_if.step) got = 1'b1;
    end
    chk("pulse_timeout", 32'(got), 32'd1);
  endtask

  // Runs cycles and counts step pulses seen.
  task automatic quiet(input int cycles, output int steps);
    steps = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus_if.step || bus_if.up || bus_if.down || bus_if.left || bus_if.right) steps++;
    end
  endtask

  function automatic logic [31:0] udlr();
    return {28'd0, bus_if.up, bus_if.down, bus_if.left, bus_if.right};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus_if.key_up = 1'b0;
    bus_if.key_down = 1'b0;
    bus_if.key_left = 1'b0;
    bus_if.key_right = 1'b0;
    bus_if.pause = 1'b0;
    bus_if.dead = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_dir", 32'(bus_if.dir), 32'd3);
    chk("rst_pulses", udlr(), 32'd0);
    chk("rst_step", 32'(bus_if.step), 32'd0);
    reset = 1'b1;

    // 1: up from IDLE, accepted on the third edge, first pulse 4 edges later
    press_up();
    tick();
    chk("t1_still_idle", 32'(dbg_state), 32'd0);
    tick();
    chk("t1_run", 32'(dbg_state), 32'd1);
    chk("t1_dir_before_step", 32'(bus_if.dir), 32'd3);
    wait_pulse(8, n);
    chk("t1_first_lat", 32'(n), 32'd4);
    chk("t1_first_up", udlr(), 32'b1000);
    chk("t1_dir_up", 32'(bus_if.dir), 32'd0);
    wait_pulse(8, n);
    chk("t1_period", 32'(n), 32'd4);
    chk("t1_second_up", udlr(), 32'b1000);

    // 2: turn right, then a left press is a reversal and is rejected
    press_right();
    wait_pulse(8, n);
    chk("t2_lat_right", 32'(n), 32'd3);
    chk("t2_right", udlr(), 32'b0001);
    chk("t2_dir_right", 32'(bus_if.dir), 32'd3);
    press_left();
    wait_pulse(8, n);
    chk("t2_lat_rej", 32'(n), 32'd3);
    chk("t2_still_right", udlr(), 32'b0001);
    chk("t2_dir_kept", 32'(bus_if.dir), 32'd3);
    wait_pulse(8, n);
    chk("t2_period", 32'(n), 32'd4);
    chk("t2_right_again", udlr(), 32'b0001);

    // 3: up then left one clk later in one step: left checked against RIGHT
    press_up();
    press_left();
    wait_pulse(8, n);
    chk("t3_lat", 32'(n), 32'd2);
    chk("t3_up", udlr(), 32'b1000);
    chk("t3_dir_up", 32'(bus_if.dir), 32'd0);
    press_left();
    wait_pulse(8, n);
    chk("t3_lat_left", 32'(n), 32'd3);
    chk("t3_left", udlr(), 32'b0010);
    chk("t3_dir_left", 32'(bus_if.dir), 32'd2);

    // 4: pause mid-step freezes the count; resume finishes the remainder
    tick();
    tick();
    bus_if.pause = 1'b1;
    quiet(10, cnt);
    chk("t4_no_pulse", 32'(cnt), 32'd0);
    chk("t4_dir_frozen", 32'(bus_if.dir), 32'd2);
    bus_if.pause = 1'b0;
    wait_pulse(8, n);
    chk("t4_remaining", 32'(n), 32'd2);
    chk("t4_left", udlr(), 32'b0010);
    // pause exactly at the terminal count: pulse deferred to first edge after release
    repeat (3) tick();
    bus_if.pause = 1'b1;
    quiet(3, cnt);
    chk("t4_term_no_pulse", 32'(cnt), 32'd0);
    bus_if.pause = 1'b0;
    wait_pulse(8, n);
    chk("t4_term_resume", 32'(n), 32'd1);
    chk("t4_term_left", udlr(), 32'b0010);

    // 5: simultaneous up and left edges: up wins, left not queued
    bus_if.key_up = 1'b1;
    bus_if.key_left = 1'b1;
    tick();
    bus_if.key_up = 1'b0;
    bus_if.key_left = 1'b0;
    wait_pulse(8, n);
    chk("t5_lat", 32'(n), 32'd3);
    chk("t5_up_wins", udlr(), 32'b1000);
    chk("t5_dir_up", 32'(bus_if.dir), 32'd0);
    wait_pulse(8, n);
    chk("t5_no_left_pending", udlr(), 32'b1000);

    // 6: dead is terminal until reset
    tick();
    bus_if.dead = 1'b1;
    tick();
    bus_if.dead = 1'b0;
    chk("t6_dead_state", 32'(dbg_state), 32'd2);
    press_left();
    press_down();
    quiet(12, cnt);
    chk("t6_silent", 32'(cnt), 32'd0);
    chk("t6_still_dead", 32'(dbg_state), 32'd2);
    chk("t6_dir_frozen", 32'(bus_if.dir), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_rst_state", 32'(dbg_state), 32'd0);
    chk("t6_rst_dir", 32'(bus_if.dir), 32'd3);
    chk("t6_rst_outputs", udlr(), 32'd0);
    tick();
    reset = 1'b1;

    // Reset during a live pulse drops it at once
    press_right();
    wait_pulse(10, n);
    chk("rst_mid_lat", 32'(n), 32'd6);
    chk("rst_mid_right", udlr(), 32'b0001);
    reset = 1'b0;
    #1;
    chk("rst_mid_drop", udlr(), 32'd0);
    chk("rst_mid_step", 32'(bus_if.step), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
